// File: rtl/hls_pipe_ctrl_if.sv
// Handshake/status bundle between hls_pipe_ctrl and its stream source/sink.
// Optional perf counter signals exist only when HLS_PIPE_CTRL_PERF_EN is defined.
interface hls_pipe_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic             stage_en;
  logic             busy;
  logic [CNT_W-1:0] inflight;
  logic [1:0]       state;
`ifdef HLS_PIPE_CTRL_PERF_EN
  logic [31:0]      perf_tokens;
  logic [31:0]      perf_stalls;

  modport slave (
    input  in_valid, out_ready, flush,
    output in_ready, out_valid, stage_en, busy, inflight, state,
           perf_tokens, perf_stalls
  );
  modport master (
    output in_valid, out_ready, flush,
    input  in_ready, out_valid, stage_en, busy, inflight, state,
           perf_tokens, perf_stalls
  );
`else
  modport slave (
    input  in_valid, out_ready, flush,
    output in_ready, out_valid, stage_en, busy, inflight, state
  );
  modport master (
    output in_valid, out_ready, flush,
    input  in_ready, out_valid, stage_en, busy, inflight, state
  );
`endif
endinterface

// File: rtl/hls_pipe_ctrl.sv
// Sequencing controller for a fixed-latency HLS pipeline: valid chain, II gating, stall and flush.
// Define HLS_PIPE_CTRL_PERF_EN to add saturating perf_tokens / perf_stalls counters.
module hls_pipe_ctrl #(
  parameter int LATENCY = 40,
  parameter int II      = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  hls_pipe_ctrl_if.slave   bus
);

  localparam int II_W = (II > 1) ? $clog2(II) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LATENCY-1:0] vchain_q, vchain_d;
  logic [II_W-1:0]    ii_cnt_q, ii_cnt_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  logic out_valid;
  logic stage_en;
  logic in_ready;
  logic accept;
  logic emit;
  logic clear;

  // A flush request blanks both handshakes in its own cycle so neither side sees a transfer.
  assign out_valid = vchain_q[LATENCY-1] && (state_q != FLUSH) && !bus.flush;
  assign stage_en  = !(out_valid && !bus.out_ready) && (state_q != FLUSH);
  assign in_ready  = stage_en && (ii_cnt_q == '0) && !bus.flush;
  assign accept    = bus.in_valid && in_ready;
  assign emit      = out_valid && bus.out_ready;
  assign clear     = bus.flush || (state_q == FLUSH);

  always_comb begin
    vchain_d = vchain_q;
    if (clear) begin
      vchain_d = '0;
    end else if (stage_en) begin
      vchain_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) begin
        vchain_d[i] = vchain_q[i-1];
      end
    end
  end

  always_comb begin
    ii_cnt_d = ii_cnt_q;
    if (clear) begin
      ii_cnt_d = '0;
    end else if (accept) begin
      ii_cnt_d = II_W'(II - 1);
    end else if (stage_en && (ii_cnt_q != '0)) begin
      ii_cnt_d = ii_cnt_q - 1'b1;
    end
  end

  // Guards against wrap are defensive; the valid chain bounds occupancy to LATENCY.
  always_comb begin
    inflight_d = inflight_q;
    if (clear) begin
      inflight_d = '0;
    end else if (accept && !emit && (inflight_q != '1)) begin
      inflight_d = inflight_q + 1'b1;
    end else if (emit && !accept && (inflight_q != '0)) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.flush)  state_d = FLUSH;
        else if (accept) state_d = RUN;
      end
      RUN: begin
        if (bus.flush)                           state_d = FLUSH;
        else if (out_valid && !bus.out_ready)    state_d = STALL;
        else if ((inflight_d == '0) && !accept)  state_d = IDLE;
      end
      STALL: begin
        if (bus.flush)          state_d = FLUSH;
        else if (bus.out_ready) state_d = RUN;
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      vchain_q   <= '0;
      ii_cnt_q   <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      vchain_q   <= vchain_d;
      ii_cnt_q   <= ii_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.stage_en  = stage_en;
  assign bus.busy      = (inflight_q != '0);
  assign bus.inflight  = inflight_q;
  assign bus.state     = state_q;

`ifdef HLS_PIPE_CTRL_PERF_EN
  logic [31:0] perf_tokens_q, perf_tokens_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Counters saturate and deliberately ignore flush.
  always_comb begin
    perf_tokens_d = perf_tokens_q;
    perf_stalls_d = perf_stalls_q;
    if (emit && (perf_tokens_q != '1))               perf_tokens_d = perf_tokens_q + 1'b1;
    if ((state_q == STALL) && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_tokens_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_tokens_q <= perf_tokens_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign bus.perf_tokens = perf_tokens_q;
  assign bus.perf_stalls = perf_stalls_q;
`endif

endmodule

// File: doc/hls_pipe_ctrl.md
Name: hls_pipe_ctrl

Overview:
Sequencing controller for a statically scheduled HLS dataflow graph: the split, kernel, merge and delay-balancing instances that make up one top-level pipeline of fixed total latency. It owns the input/output valid-ready handshakes and drives a single global advance enable (stage_en) into every datapath instance. It tracks in-flight tokens with a valid shift chain mirroring the datapath latency, enforces the initiation interval, and supports flush. Sits between the stream source/sink and the generated main datapath.

Parameters:
LATENCY, 40, total datapath latency in cycles from accepted input to valid output (>=1)
II, 1, initiation interval in advancing cycles between accepted tokens (>=1)
CNT_W, 8, width of the in-flight counter (must satisfy 2^CNT_W > LATENCY)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  source offers a token
in_ready  out  1  controller accepts the token this cycle
out_valid  out  1  datapath output token valid
out_ready  in  1  sink accepts the output token
flush  in  1  synchronous request to discard all in-flight tokens
stage_en  out  1  global advance enable to all datapath instances
busy  out  1  at least one token in flight
inflight  out  CNT_W  number of tokens in flight
state  out  2  FSM state: 0 IDLE, 1 RUN, 2 STALL, 3 FLUSH

Behaviour:
- Reset (async assert, sync-style release on clock): vchain=0, ii_cnt=0, inflight=0, state=IDLE; outputs in_ready=1, out_valid=0, stage_en=1, busy=0.
- vchain[LATENCY-1:0]: out_valid = vchain[LATENCY-1].
- stage_en = !(out_valid && !out_ready) && state!=FLUSH; combinational.
- in_ready = stage_en && ii_cnt==0; combinational; independent of in_valid.
- accept = in_valid && in_ready; emit = out_valid && out_ready.
- When stage_en=1: vchain shifts by one, vchain[0] <= accept. When stage_en=0: vchain holds.
- ii_cnt: on accept load II-1; else if stage_en and ii_cnt!=0 decrement; holds while stalled. II=1 means in_ready never gated by ii_cnt.
- inflight: +1 on accept, -1 on emit, unchanged when both same cycle. Never wraps.
- Latency: token accepted at cycle t with no stalls yields out_valid at cycle t+LATENCY; each stall cycle adds one.
- busy = (inflight != 0).
- FSM:
  IDLE: inflight==0. accept -> RUN. flush -> FLUSH.
  RUN: out_valid && !out_ready -> STALL; inflight==0 after update and no accept -> IDLE; flush -> FLUSH.
  STALL: stage_en=0, in_ready=0. out_ready -> RUN (emit occurs that cycle); flush -> FLUSH.
  FLUSH: one cycle; vchain<=0, ii_cnt<=0, inflight<=0; stage_en=0, in_ready=0, out_valid forced 0; next IDLE.
- flush has priority over accept and emit in the same cycle; the entering-flush cycle does not accept or emit.
- Reset mid-operation discards all in-flight tokens immediately; no output produced afterwards.
- Datapath contents after flush are don't-care; only vchain qualifies outputs.

Optional Feature:
HLS_PIPE_CTRL_PERF_EN: when defined, adds outputs perf_tokens (32 bit, increments on emit) and perf_stalls (32 bit, increments each cycle in STALL). Both reset to 0, saturate at all-ones, and are unaffected by flush. When undefined, these ports and counters do not exist; all other behaviour identical.

Test Plan:
LATENCY=4, II=1, out_ready=1, single in_valid pulse at cycle 0 -> out_valid high exactly cycle 4 for one cycle; inflight 1 during cycles 1-4, 0 at cycle 5; state IDLE->RUN->IDLE.
LATENCY=4, II=1, in_valid held 10 cycles, out_ready=1 -> 10 consecutive out_valid beats starting cycle 4; in_ready constant 1; inflight peaks at 4.
LATENCY=4, II=3, in_valid held -> accepts at cycles 0,3,6; out_valid at 4,7,10; in_ready low two cycles after each accept.
LATENCY=4, stream running, out_ready low for 3 cycles while out_valid=1 -> stage_en=0 and in_ready=0 for 3 cycles, state=STALL, no token lost or duplicated; total emitted count equals accepted count.
LATENCY=4, 3 tokens in flight, flush pulse -> next cycle state=FLUSH, then IDLE, inflight=0, out_valid never asserts for those tokens.
Reset asserted mid-stream with 2 tokens in flight -> outputs immediately at reset values; after release, fresh token emerges after exactly 4 cycles; with HLS_PIPE_CTRL_PERF_EN, perf counters read 0.
